tile_walker: RTL and testbench

Consumes one per-tile setup record from the tile setup stage: tile origin, edge deltas, initial edge values, color, dz/dx, dz/dy and origin z. Walks the 32×32 pixel tile in raster order, stepping the three edge functions and z incrementally. Emits one fragment (pixel x, pixel y, z, color) for every pixel inside the triangle over a valid/ready handshake. It is the downstream receiver of the tile setup handshake and feeds the depth/fragment stage.

---
 rtl/tile_walker_pkg.sv | 50 +++++
 rtl/raster_stepper.sv | 43 ++++
 rtl/tile_walker.sv | 188 ++++++++++++++++++
 tb/tb_tile_walker.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_walker_pkg.sv
// Shared types and constants for the tile walker: setup record, fragment,
// walker state and fixed-point helpers.
package tile_walker_pkg;

    localparam int TILE_DIM      = 32;
    localparam int FX_TOTAL_BITS = 16;
    localparam int FX_FRAC_BITS  = 4;
    localparam int ACC_W         = 2 * FX_TOTAL_BITS;
    localparam int PIX_W         = FX_TOTAL_BITS - FX_FRAC_BITS;

    typedef struct packed {
        logic signed [FX_TOTAL_BITS-1:0] x;
        logic signed [FX_TOTAL_BITS-1:0] y;
        logic signed [FX_TOTAL_BITS-1:0] z;
    } coord_3d_t;

    typedef struct packed {
        coord_3d_t                       abs_pos;
        coord_3d_t                       delta_0;
        coord_3d_t                       delta_1;
        coord_3d_t                       delta_2;
        logic signed [ACC_W-1:0]         edge_0;
        logic signed [ACC_W-1:0]         edge_1;
        logic signed [ACC_W-1:0]         edge_2;
        logic [3:0]                      color;
        logic signed [FX_TOTAL_BITS-1:0] dzdx;
        logic signed [FX_TOTAL_BITS-1:0] dzdy;
        logic signed [ACC_W-1:0]         z_current;
    } tile_setup_t;

    typedef struct packed {
        logic [PIX_W-1:0] x;
        logic [PIX_W-1:0] y;
        logic [ACC_W-1:0] z;
        logic [3:0]       color;
    } fragment_t;

    typedef enum logic {IDLE, WALK} walker_state_t;

    // Sign-extend a fixed-point word to accumulator width.
    function automatic logic [ACC_W-1:0] fx_sext(input logic [FX_TOTAL_BITS-1:0] v);
        return {{(ACC_W-FX_TOTAL_BITS){v[FX_TOTAL_BITS-1]}}, v};
    endfunction

    // Edge step: sign-extended delta scaled by one integer pixel.
    function automatic logic [ACC_W-1:0] fx_step(input logic [FX_TOTAL_BITS-1:0] v);
        return fx_sext(v) << FX_FRAC_BITS;
    endfunction

endpackage

// File: rtl/raster_stepper.sv
// One incremental accumulator with a row-start register. Column advance adds
// the x-step; a row wrap reloads from row start plus the y-step.
module raster_stepper #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_adv,
    input  logic         i_wrap,
    input  logic [W-1:0] i_init,
    input  logic [W-1:0] i_xstep,
    input  logic [W-1:0] i_ystep,
    output logic [W-1:0] o_acc
);

    logic [W-1:0] r_acc;
    logic [W-1:0] r_row;
    logic [W-1:0] w_row_next;

    assign w_row_next = r_row + i_ystep;

    // Accumulator and row-start update; all arithmetic wraps modulo 2^W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_row <= '0;
        end else if (i_load) begin
            r_acc <= i_init;
            r_row <= i_init;
        end else if (i_adv) begin
            if (i_wrap) begin
                r_acc <= w_row_next;
                r_row <= w_row_next;
            end else begin
                r_acc <= r_acc + i_xstep;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/tile_walker.sv
// Tile walker: captures one setup record, walks the tile in raster order and
// emits a fragment for every pixel inside all three edges.
// Optional: define RASTER_FRAG_COUNT_EN to add the frag_count output.
module tile_walker
    import tile_walker_pkg::*;
#(
    parameter int TILE_DIM      = tile_walker_pkg::TILE_DIM,
    parameter int FX_TOTAL_BITS = tile_walker_pkg::FX_TOTAL_BITS,
    parameter int FX_FRAC_BITS  = tile_walker_pkg::FX_FRAC_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            vld_in,
    output logic                            rdy_in,
    input  coord_3d_t                       in_abs_pos,
    input  coord_3d_t                       in_delta_0,
    input  coord_3d_t                       in_delta_1,
    input  coord_3d_t                       in_delta_2,
    input  logic signed [2*FX_TOTAL_BITS-1:0] in_edge_0,
    input  logic signed [2*FX_TOTAL_BITS-1:0] in_edge_1,
    input  logic signed [2*FX_TOTAL_BITS-1:0] in_edge_2,
    input  logic [3:0]                      in_color,
    input  logic signed [FX_TOTAL_BITS-1:0] in_dzdx,
    input  logic signed [FX_TOTAL_BITS-1:0] in_dzdy,
    input  logic signed [2*FX_TOTAL_BITS-1:0] in_z_current,
    output logic                            vld_out,
    input  logic                            rdy_out,
    output logic [11:0]                     out_x,
    output logic [11:0]                     out_y,
    output logic [2*FX_TOTAL_BITS-1:0]      out_z,
    output logic [3:0]                      out_color,
    output logic                            tile_done
`ifdef RASTER_FRAG_COUNT_EN
    ,
    output logic [10:0]                     frag_count
`endif
);

    localparam int AW = 2 * FX_TOTAL_BITS;
    localparam int CW = $clog2(TILE_DIM);

    tile_setup_t          w_setup;
    walker_state_t        r_state, w_state_nxt;
    logic                 w_cap, w_rdy_in;
    logic [CW-1:0]        r_col, r_row;
    logic [11:0]          r_org_x, r_org_y;
    logic [3:0]           r_color;
    logic [3:0][AW-1:0]   r_xstep, r_ystep, w_init, w_acc;
    logic                 w_walk, w_inside, w_can_load, w_adv, w_load, w_wrap, w_last;
    fragment_t            r_frag;
    logic                 r_vld_out, r_tile_done;
    logic                 w_unused_bits;

    assign w_setup = '{abs_pos: in_abs_pos, delta_0: in_delta_0, delta_1: in_delta_1,
                       delta_2: in_delta_2, edge_0: in_edge_0, edge_1: in_edge_1,
                       edge_2: in_edge_2, color: in_color, dzdx: in_dzdx,
                       dzdy: in_dzdy, z_current: in_z_current};

    // Only x/y of the coordinate records and the integer part of the origin matter.
    assign w_unused_bits = ^{w_setup.abs_pos.z, w_setup.abs_pos.x[FX_FRAC_BITS-1:0],
                             w_setup.abs_pos.y[FX_FRAC_BITS-1:0], w_setup.delta_0.z,
                             w_setup.delta_1.z, w_setup.delta_2.z};

    // Lanes 0..2 are the edge functions, lane 3 is z.
    assign w_init = {w_setup.z_current, w_setup.edge_2, w_setup.edge_1, w_setup.edge_0};

    assign w_walk     = (r_state == WALK);
    assign w_inside   = !w_acc[0][AW-1] && !w_acc[1][AW-1] && !w_acc[2][AW-1];
    assign w_can_load = !r_vld_out || rdy_out;
    // Outside pixels never wait; inside pixels wait for a free output register.
    assign w_adv      = w_walk && (!w_inside || w_can_load);
    assign w_load     = w_walk && w_inside && w_can_load;
    assign w_wrap     = (r_col == CW'(TILE_DIM - 1));
    assign w_last     = w_wrap && (r_row == CW'(TILE_DIM - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, setup handshake and capture strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy_in    = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdy_in = 1'b1;
                if (vld_in) begin
                    w_cap       = 1'b1;
                    w_state_nxt = WALK;
                end
            end
            WALK: if (w_adv && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture per-tile constants: pixel origin, color and precomputed steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_org_x <= '0;
            r_org_y <= '0;
            r_color <= '0;
            r_xstep <= '0;
            r_ystep <= '0;
        end else if (w_cap) begin
            r_org_x <= w_setup.abs_pos.x[FX_TOTAL_BITS-1:FX_FRAC_BITS];
            r_org_y <= w_setup.abs_pos.y[FX_TOTAL_BITS-1:FX_FRAC_BITS];
            r_color <= w_setup.color;
            r_xstep <= {fx_sext(w_setup.dzdx), fx_step(w_setup.delta_2.y),
                        fx_step(w_setup.delta_1.y), fx_step(w_setup.delta_0.y)};
            r_ystep <= {fx_sext(w_setup.dzdy), fx_step(w_setup.delta_2.x),
                        fx_step(w_setup.delta_1.x), fx_step(w_setup.delta_0.x)};
        end
    end

    // Raster position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_cap) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_adv) begin
            r_col <= r_col + CW'(1);
            if (w_wrap) r_row <= r_row + CW'(1);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        raster_stepper #(.W(AW)) u_step (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_cap),
            .i_adv   (w_adv),
            .i_wrap  (w_wrap),
            .i_init  (w_init[g]),
            .i_xstep (r_xstep[g]),
            .i_ystep (r_ystep[g]),
            .o_acc   (w_acc[g])
        );
    end

    // Output register: independent of the FSM, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_out <= 1'b0;
            r_frag    <= '0;
        end else if (w_load) begin
            r_vld_out <= 1'b1;
            r_frag    <= '{x: r_org_x + 12'(r_col), y: r_org_y + 12'(r_row),
                           z: w_acc[3], color: r_color};
        end else if (rdy_out) begin
            r_vld_out <= 1'b0;
        end
    end

    // End-of-tile pulse, one cycle after the last pixel advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tile_done <= 1'b0;
        else        r_tile_done <= w_adv && w_last;
    end

`ifdef RASTER_FRAG_COUNT_EN
    logic [10:0] r_frag_count;

    // Fragments handed off for the current tile; cleared on the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_frag_count <= '0;
        else if (w_cap)                 r_frag_count <= '0;
        else if (r_vld_out && rdy_out)  r_frag_count <= r_frag_count + 11'd1;
    end

    assign frag_count = r_frag_count;
`endif

    assign rdy_in    = w_rdy_in;
    assign vld_out   = r_vld_out;
    assign out_x     = r_frag.x;
    assign out_y     = r_frag.y;
    assign out_z     = r_frag.z;
    assign out_color = r_frag.color;
    assign tile_done = r_tile_done;

endmodule

// File: tb/tb_tile_walker.sv
// Randomized and directed bench for tile_walker with a closed-form pixel model.
`timescale 1ns/1ps
module tb_tile_walker;
    import tile_walker_pkg::*;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [31:0] z;
        logic [3:0]  c;
    } ef_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld_in = 1'b0;
    logic               rdy_in;
    coord_3d_t          in_abs_pos = '0, in_delta_0 = '0, in_delta_1 = '0, in_delta_2 = '0;
    logic signed [31:0] in_edge_0 = '0, in_edge_1 = '0, in_edge_2 = '0, in_z_current = '0;
    logic [3:0]         in_color = '0;
    logic signed [15:0] in_dzdx = '0, in_dzdy = '0;
    logic               vld_out;
    logic               rdy_out = 1'b1;
    logic [11:0]        out_x, out_y;
    logic [31:0]        out_z;
    logic [3:0]         out_color;
    logic               tile_done;
`ifdef RASTER_FRAG_COUNT_EN
    logic [10:0]        frag_count;
`endif

    tile_walker dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
        .in_abs_pos(in_abs_pos), .in_delta_0(in_delta_0), .in_delta_1(in_delta_1),
        .in_delta_2(in_delta_2), .in_edge_0(in_edge_0), .in_edge_1(in_edge_1),
        .in_edge_2(in_edge_2), .in_color(in_color), .in_dzdx(in_dzdx), .in_dzdy(in_dzdy),
        .in_z_current(in_z_current), .vld_out(vld_out), .rdy_out(rdy_out),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_color(out_color),
        .tile_done(tile_done)
`ifdef RASTER_FRAG_COUNT_EN
        , .frag_count(frag_count)
`endif
    );

    always #5 clk = ~clk;

    int  total = 0, bad = 0, cyc = 0;
    ef_t exp_q[$];
    int  acc_cyc = 0, tile_id = 0, first_id = 0, tile_base = 0, cur_n = 0;
    int  n_hand = 0, done_seen = 0, stall_left = 0;
    bit  cur_first_in = 0, nobp = 1, bp_mode = 0, stall_req = 0, stall_used = 0;
    logic [11:0] org_x = '0, org_y = '0;
    logic        prev_stall = 1'b0, pend;
    logic [59:0] held;
    ef_t         ce;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endfunction

    // ---- reference model: closed-form value of every pixel ----
    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic void model_px(input tile_setup_t s, input int c, input int r,
                                     output bit ins, output ef_t f);
        logic [31:0] e0, e1, e2;
        logic [15:0] px, py;
        e0 = s.edge_0 + 32'(c) * sx(s.delta_0.y) * 16 + 32'(r) * sx(s.delta_0.x) * 16;
        e1 = s.edge_1 + 32'(c) * sx(s.delta_1.y) * 16 + 32'(r) * sx(s.delta_1.x) * 16;
        e2 = s.edge_2 + 32'(c) * sx(s.delta_2.y) * 16 + 32'(r) * sx(s.delta_2.x) * 16;
        ins = !e0[31] && !e1[31] && !e2[31];
        px = s.abs_pos.x;
        py = s.abs_pos.y;
        f.x = px[15:4] + 12'(c);
        f.y = py[15:4] + 12'(r);
        f.z = s.z_current + 32'(c) * sx(s.dzdx) + 32'(r) * sx(s.dzdy);
        f.c = s.color;
    endfunction

    function automatic int count_in(input tile_setup_t s);
        bit ins; ef_t f; int n;
        n = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                model_px(s, c, r, ins, f);
                if (ins) n++;
            end
        return n;
    endfunction

    task automatic gen_tile(input tile_setup_t s, output int n, output bit fi);
        bit ins; ef_t f;
        n = 0; fi = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                model_px(s, c, r, ins, f);
                if (ins) begin
                    exp_q.push_back(f);
                    n++;
                    if (r == 0 && c == 0) fi = 1;
                end
            end
    endtask

    function automatic tile_setup_t mk(input int ox, input int oy, input logic [31:0] e,
                                       input logic [31:0] z0, input logic [3:0] col);
        tile_setup_t s;
        s = '0;
        s.abs_pos.x = 16'(ox * 16);
        s.abs_pos.y = 16'(oy * 16);
        s.edge_0 = e; s.edge_1 = e; s.edge_2 = e;
        s.z_current = z0;
        s.color = col;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: steady, random, or a single 10-cycle stall at fragment 5.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            rdy_out = 1'b0;
            stall_left--;
        end else if (stall_req && !stall_used && (n_hand - tile_base) == 5) begin
            rdy_out = 1'b0;
            stall_left = 9;
            stall_used = 1;
        end else if (bp_mode) begin
            rdy_out = 1'($urandom_range(0, 1));
        end else begin
            rdy_out = 1'b1;
        end
        if (!stall_req) stall_used = 0;
    end

    // Compare process: fragment order/content, stall stability, first-fragment
    // latency and end-of-tile bookkeeping.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {vld_out, out_x, out_y, out_z, out_color}, {1'b1, held});
            if (vld_out && tile_id != first_id) begin
                first_id = tile_id;
                if (cur_first_in) begin
                    chk("first_latency", cyc - acc_cyc, 1);
                    chk("first_xy", {out_x, out_y}, {org_x, org_y});
                end
            end
            if (vld_out && rdy_out) begin
                if (exp_q.size() == 0) begin
                    chk("extra_frag", {out_x, out_y}, 0);
                end else begin
                    ce = exp_q.pop_front();
                    chk("frag", {out_x, out_y, out_z, out_color}, {ce.x, ce.y, ce.z, ce.c});
                end
                n_hand++;
            end
            prev_stall = vld_out && !rdy_out;
            held = {out_x, out_y, out_z, out_color};
            if (tile_done) begin
                pend = vld_out && !rdy_out;
                chk("done_rdy_in", rdy_in, 1);
                chk("done_count", n_hand - tile_base + int'(pend), cur_n);
                chk("done_queue", exp_q.size(), int'(pend));
                if (nobp) chk("done_latency", cyc - acc_cyc, 1024);
`ifdef RASTER_FRAG_COUNT_EN
                chk("frag_count", frag_count, cur_n - int'(vld_out));
`endif
                done_seen++;
            end
        end
    end

    task automatic drive(input tile_setup_t s);
        in_abs_pos = s.abs_pos;  in_delta_0 = s.delta_0; in_delta_1 = s.delta_1;
        in_delta_2 = s.delta_2;  in_edge_0 = s.edge_0;   in_edge_1 = s.edge_1;
        in_edge_2 = s.edge_2;    in_color = s.color;     in_dzdx = s.dzdx;
        in_dzdy = s.dzdy;        in_z_current = s.z_current;
    endtask

    task automatic run_tile(input tile_setup_t s, input bit bp, input bit stall, input int abort_at);
        int n, w, d0;
        bit fi;
        logic [15:0] px, py;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin @(posedge clk); w++; end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
        bp_mode = bp; stall_req = stall; nobp = !bp && !stall;
        gen_tile(s, n, fi);
        px = s.abs_pos.x; py = s.abs_pos.y;
        org_x = px[15:4]; org_y = py[15:4];
        cur_n = n;
        tile_base = n_hand;
        d0 = done_seen;
        drive(s);
        vld_in = 1'b1;
        @(posedge clk); #1;
        vld_in = 1'b0;
        acc_cyc = cyc;
        cur_first_in = fi;
        tile_id++;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_vld_out", vld_out, 0);
            chk("rst_rdy_in", rdy_in, 1);
            chk("rst_outs", {tile_done, out_x, out_y, out_z, out_color}, 0);
`ifdef RASTER_FRAG_COUNT_EN
            chk("rst_frag_count", frag_count, 0);
`endif
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
        end
        w = 0;
        while (done_seen == d0 && w < 5000) begin
            @(posedge clk); #1;
            // Setup traffic during the walk must be ignored.
            if (bp && w < 500) begin
                vld_in = 1'($urandom_range(0, 1));
                in_edge_0 = $urandom;
            end else begin
                vld_in = 1'b0;
            end
            w++;
        end
        vld_in = 1'b0;
        if (done_seen == d0) chk("done_timeout", 0, 1);
    endtask

    tile_setup_t full, empty, grad, half, rnd;
    bit  p_ins;
    ef_t p_f;

    initial begin
        full  = mk(64, 32, 32'h100, 32'h500, 4'hA);
        empty = full; empty.edge_0 = -32'sd1;
        grad  = full; grad.dzdx = 16'sd16; grad.dzdy = 16'sd512;
        half  = full; half.edge_0 = 32'sd240; half.edge_1 = 32'h10000; half.edge_2 = 32'h10000;
        half.delta_0.y = -16'sd1;

        // Hand-computed expectations pinning the model.
        chk("pin_full_n", count_in(full), 1024);
        chk("pin_empty_n", count_in(empty), 0);
        chk("pin_half_n", count_in(half), 512);
        model_px(grad, 3, 2, p_ins, p_f);
        chk("pin_grad_z", p_f.z, 32'h930);
        model_px(full, 31, 31, p_ins, p_f);
        chk("pin_full_last", {p_f.x, p_f.y, p_f.z}, {12'd95, 12'd63, 32'h500});
        model_px(half, 16, 5, p_ins, p_f);
        chk("pin_half_col16", p_ins, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rdy_in, vld_out, tile_done, out_x, out_y, out_z, out_color},
            {1'b1, 1'b0, 1'b0, 60'd0});
`ifdef RASTER_FRAG_COUNT_EN
        chk("reset_frag_count", frag_count, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_tile(full, 0, 0, 0);
        run_tile(empty, 0, 0, 0);
        run_tile(grad, 0, 0, 0);
        run_tile(full, 0, 1, 0);
        run_tile(half, 0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            rnd = '0;
            rnd.abs_pos.x = 16'($urandom); rnd.abs_pos.y = 16'($urandom);
            rnd.delta_0.x = 16'(int'($urandom_range(0, 40)) - 20);
            rnd.delta_0.y = 16'(int'($urandom_range(0, 40)) - 20);
            rnd.delta_1.x = 16'(int'($urandom_range(0, 40)) - 20);
            rnd.delta_1.y = 16'(int'($urandom_range(0, 40)) - 20);
            rnd.delta_2.x = 16'(int'($urandom_range(0, 40)) - 20);
            rnd.delta_2.y = 16'(int'($urandom_range(0, 40)) - 20);
            rnd.edge_0 = 32'(int'($urandom_range(0, 1200)) - 300);
            rnd.edge_1 = 32'(int'($urandom_range(0, 1200)) - 300);
            rnd.edge_2 = 32'(int'($urandom_range(0, 1200)) - 300);
            rnd.color = 4'($urandom);
            rnd.dzdx = 16'($urandom); rnd.dzdy = 16'($urandom);
            rnd.z_current = $urandom;
            run_tile(rnd, 1, 0, 0);
        end
        run_tile(full, 0, 0, 300);
        run_tile(grad, 0, 0, 0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
